// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// master: the producer/consumer side (multiplier array + accumulator).
// slave:  the adder itself.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One BLOCK-bit lookahead group is resolved per stage; the group carry is
// registered between stages. Unresolved operand groups ride a shrinking skew
// chain, resolved sum bits ride a growing chain. The last stage register is
// the output register. Modes: 00 add, 01 a-b, 10 add+cin, 11 signed sat add.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int unsigned NGRP = WIDTH / BLOCK;

  logic             en;
  logic [WIDTH-1:0] b_pre;
  logic             c0;

  // Stage-0 operand preconditioning: invert b and force carry-in for subtract.
  always_comb begin
    b_pre = bus.b;
    c0    = 1'b0;
    case (bus.mode)
      2'b01: begin
        b_pre = ~bus.b;
        c0    = 1'b1;
      end
      2'b10:   c0 = bus.cin;
      default: c0 = 1'b0;
    endcase
  end

  for (genvar k = 0; k < NGRP; k++) begin : stg
    // SW: sum bits resolved once this stage has registered.
    localparam int unsigned SW = (k + 1) * BLOCK;

    logic [BLOCK-1:0] ga, gb, gs, p, g;
    logic [BLOCK:0]   cc;
    logic             term;
    logic             ci, gc, vi;
    logic [1:0]       md;
    logic [SW-1:0]    s_raw, s_next, r_s;
    logic             r_c, r_v;

    if (k == 0) begin : src
      assign ga    = bus.a[BLOCK-1:0];
      assign gb    = b_pre[BLOCK-1:0];
      assign ci    = c0;
      assign md    = bus.mode;
      assign vi    = bus.in_valid;
      assign s_raw = gs;
    end else begin : src
      assign ga    = stg[k-1].sk.r_a[BLOCK-1:0];
      assign gb    = stg[k-1].sk.r_b[BLOCK-1:0];
      assign ci    = stg[k-1].r_c;
      assign md    = stg[k-1].sk.r_m;
      assign vi    = stg[k-1].r_v;
      assign s_raw = {gs, stg[k-1].r_s};
    end

    // Full lookahead inside the group: every carry is a flat sum of products.
    always_comb begin
      p    = ga ^ gb;
      g    = ga & gb;
      cc   = '0;
      term = 1'b0;
      for (int unsigned i = 0; i <= BLOCK; i++) begin
        term = ci;
        for (int unsigned j = 0; j < i; j++) term = term & p[j];
        cc[i] = term;
        for (int unsigned j = 0; j < i; j++) begin
          term = g[j];
          for (int unsigned m = j + 1; m < i; m++) term = term & p[m];
          cc[i] = cc[i] | term;
        end
      end
    end

    assign gs = p ^ cc[BLOCK-1:0];
    assign gc = cc[BLOCK];

    if (k < NGRP - 1) begin : sk
      // RW: operand bits still waiting for later groups.
      localparam int unsigned RW = WIDTH - SW;
      logic [RW-1:0] a_up, b_up, r_a, r_b;
      logic [1:0]    r_m;

      if (k == 0) begin : head
        assign a_up = bus.a[WIDTH-1:BLOCK];
        assign b_up = b_pre[WIDTH-1:BLOCK];
      end else begin : tail
        assign a_up = stg[k-1].sk.r_a[RW+BLOCK-1:BLOCK];
        assign b_up = stg[k-1].sk.r_b[RW+BLOCK-1:BLOCK];
      end

      assign s_next = s_raw;

      // Skew chain: pending operand groups and the beat's mode move with it.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
          r_m <= '0;
        end else if (en) begin
          r_a <= a_up;
          r_b <= b_up;
          r_m <= md;
        end
      end
    end else begin : fin
      logic ovf_c, r_o;

      // Carry into the MSB is the group's top internal carry.
      assign ovf_c = cc[BLOCK-1] ^ cc[BLOCK];

      // Saturate only in mode 11; ga[BLOCK-1] is a[WIDTH-1] of this beat.
      always_comb begin
        s_next = s_raw;
        if (md == 2'b11 && ovf_c) begin
          s_next = ga[BLOCK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end

      // Overflow flag register, part of the output register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_o <= 1'b0;
        else if (en) r_o <= ovf_c;
      end
    end

    // Stage register: valid, resolved sum bits and the group carry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (en) begin
        r_v <= vi;
        r_s <= s_next;
        r_c <= gc;
      end
    end
  end

  assign en            = ~stg[NGRP-1].r_v | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = stg[NGRP-1].r_v;
  assign bus.sum       = stg[NGRP-1].r_s;
  assign bus.cout      = stg[NGRP-1].r_c;
  assign bus.ovf       = stg[NGRP-1].fin.r_o;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, BLOCK=4).
module tb_pipelined_cla_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned BLOCK = 4;
  localparam int unsigned LAT   = WIDTH / BLOCK;
  localparam int unsigned NVEC  = 14;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [17:0] exp_q[$];

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [1:0]  mode;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, returns {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic [1:0] mode);
    logic [15:0] bb;
    logic        ci;
    logic [16:0] full;
    logic [15:0] s;
    logic        o;
    bb   = (mode == 2'b01) ? ~b : b;
    ci   = (mode == 2'b01) ? 1'b1 : ((mode == 2'b10) ? cin : 1'b0);
    full = {1'b0, a} + {1'b0, bb} + {16'b0, ci};
    s    = full[15:0];
    o    = (a[15] == bb[15]) && (s[15] != a[15]);
    if (mode == 2'b11 && o) s = a[15] ? 16'h8000 : 16'h7FFF;
    return {o, full[16], s};
  endfunction

  task automatic run_vec(input int idx);
    vec_t v;
    int   n;
    v = vecs[idx];
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.cin      = v.cin;
    bus.mode     = v.mode;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_latency", idx), n, LAT - 1);
    check($sformatf("v%0d_sum", idx), bus.sum, v.sum);
    check($sformatf("v%0d_cout", idx), bus.cout, v.cout);
    check($sformatf("v%0d_ovf", idx), bus.ovf, v.ovf);
  endtask

  task automatic stream();
    fork
      begin : driver
        for (int n = 0; n < 20; n++) begin
          int guard;
          guard = 0;
          @(negedge clk);
          bus.in_valid = 1'b1;
          bus.a        = 16'($urandom);
          bus.b        = 16'($urandom);
          bus.cin      = 1'($urandom);
          bus.mode     = 2'($urandom);
          #4;
          while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            #4;
            guard++;
          end
          if (guard >= 50) begin
            failures++;
            $display("FAIL stream_accept_timeout: got in_ready=0 expected 1");
          end
          exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.mode));
          @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      begin : stall
        repeat (8) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
      begin : monitor
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 20 && cyc < 300) begin
          @(negedge clk);
          #4;
          cyc++;
          check("stream_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
          if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL stream_extra: got unexpected result %0h expected none", bus.sum);
            end else if (!bus.out_ready) begin
              check("stall_hold", {bus.ovf, bus.cout, bus.sum}, exp_q[0]);
            end else begin
              check($sformatf("stream_r%0d", got), {bus.ovf, bus.cout, bus.sum}, exp_q.pop_front());
              got++;
            end
          end
        end
        check("stream_count", got, 20);
      end
    join
  endtask

  task automatic reset_midstream();
    int seen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'h1111 * 16'(i + 1);
      bus.b        = 16'h2222;
      bus.cin      = 1'b0;
      bus.mode     = 2'b00;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum", bus.sum, 16'h0000);
    check("rst_flags", {bus.cout, bus.ovf}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rst_no_ghost", seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 2'b01, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 2'b01, 16'h7FFF, 1'b1, 1'b1};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 2'b11, 16'h7FFF, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000, 16'hFFFF, 1'b0, 2'b11, 16'h8000, 1'b1, 1'b1};
    vecs[5]  = '{16'h1234, 16'h0F0F, 1'b0, 2'b11, 16'h2143, 1'b0, 1'b0};
    vecs[6]  = '{16'h00FF, 16'h0F00, 1'b1, 2'b10, 16'h1000, 1'b0, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 2'b10, 16'hFFFE, 1'b1, 1'b0};
    vecs[8]  = '{16'h0001, 16'h0001, 1'b1, 2'b00, 16'h0002, 1'b0, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, 1'b0, 2'b01, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{16'h7FFF, 16'h0001, 1'b0, 2'b00, 16'h8000, 1'b0, 1'b1};
    vecs[11] = '{16'h8000, 16'h8000, 1'b1, 2'b11, 16'h8000, 1'b1, 1'b1};
    vecs[12] = '{16'h0007, 16'h0005, 1'b0, 2'b01, 16'h0002, 1'b1, 1'b0};
    vecs[13] = '{16'hFFFF, 16'hFFFF, 1'b0, 2'b11, 16'hFFFE, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_sum", bus.sum, 16'h0000);
    check("reset_cout", bus.cout, 1'b0);
    check("reset_ovf", bus.ovf, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1'b1);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    stream();
    reset_midstream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
